iic_config_engine: RTL

Table-driven I2C master that programs video front-end/back-end chips at bring-up. It replaces fixed hard-coded write sequences with:
- an external register table
- a parametrised SCL rate
- true open-drain signalling with ACK sampling
- per-entry retry
- SCL clock stretching
- a start/busy/done/error handshake

It sits beside the video pipeline and runs once after reset, or on each software request.

---
 rtl/iic_config_engine_if.sv | 33 +++
 rtl/iic_config_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/iic_config_engine_if.sv
// iic_config_engine_if
//   Groups the control handshake, register-table port and open-drain I2C
//   line controls of iic_config_engine.
//   start/busy/done/error/err_index : run request and status
//   tbl_addr/tbl_data               : read-only register table port
//   scl_oe/sda_oe                   : 1 = pull line low, 0 = release
//   scl_in/sda_in                   : sampled pin levels
//   master modport: the engine; slave modport: controller + table + bus.
interface iic_config_engine_if #(
  parameter int IDX_W = 5
);
  logic             start;
  logic             busy;
  logic             done;
  logic             error;
  logic [IDX_W-1:0] err_index;
  logic [IDX_W-1:0] tbl_addr;
  logic [23:0]      tbl_data;
  logic             scl_oe;
  logic             sda_oe;
  logic             scl_in;
  logic             sda_in;

  modport master (
    input  start, tbl_data, scl_in, sda_in,
    output busy, done, error, err_index, tbl_addr, scl_oe, sda_oe
  );

  modport slave (
    output start, tbl_data, scl_in, sda_in,
    input  busy, done, error, err_index, tbl_addr, scl_oe, sda_oe
  );
endinterface

// File: rtl/iic_config_engine.sv
// iic_config_engine
//   Table-driven I2C write master for video chip bring-up. Each table entry
//   {slave[6:0], last, reg[7:0], data[7:0]} becomes one 3-byte write
//   transaction with ACK sampling, per-entry retry on NACK, SCL stretching
//   and a bus-free gap between transactions.
//   clock, reset : system clock, synchronous active-high reset
//   bus (master) : start/busy/done/error/err_index handshake, table port
//                  tbl_addr/tbl_data, open-drain scl_oe/sda_oe, scl_in/sda_in
module iic_config_engine #(
  parameter int CLK_RATE_MHZ = 200,
  parameter int SCL_KHZ      = 100,
  parameter int QTR_CYCLES   = (CLK_RATE_MHZ * 1000) / (SCL_KHZ * 4),
  parameter int NUM_ENTRIES  = 32,
  parameter int IDX_W        = 5,
  parameter int MAX_RETRY    = 3,
  parameter int GAP_QTRS     = 8
) (
  input logic               clock,
  input logic               reset,
  iic_config_engine_if.master bus
);

  localparam int QW = $clog2(QTR_CYCLES);
  localparam int GW = $clog2(GAP_QTRS + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_BIT   = 3'd3;
  localparam logic [2:0] S_ACK   = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;
  localparam logic [2:0] S_GAP   = 3'd6;

  logic [2:0]       r_state;
  logic [QW-1:0]    r_qcnt;
  logic [1:0]       r_qph;
  logic [2:0]       r_bitcnt;
  logic [1:0]       r_byte;
  logic [GW-1:0]    r_gap;
  logic [RW-1:0]    r_retry;
  logic [IDX_W-1:0] r_idx;
  logic [23:0]      r_frame;
  logic             r_last;
  logic             r_nack;
  logic             r_fetch2;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic [IDX_W-1:0] r_err_index;

  logic       w_active;
  logic       w_stall;
  logic       w_q;
  logic [4:0] w_pos;
  logic       w_bit;
  logic       w_scl_oe;
  logic       w_sda_oe;

  assign w_active = (r_state == S_START) || (r_state == S_BIT) || (r_state == S_ACK) ||
                    (r_state == S_STOP)  || (r_state == S_GAP);
  // Quarter timer freezes while SCL is released but still held low by a slave.
  assign w_stall  = !bus.scl_in &&
                    ((((r_state == S_BIT) || (r_state == S_ACK)) && (r_qph == 2'd2)) ||
                     ((r_state == S_STOP) && (r_qph == 2'd1)));
  assign w_q      = w_active && !w_stall && (r_qcnt == QW'(QTR_CYCLES - 1));

  // Frame bit pointer: bytes 0..2, MSB first.
  assign w_pos = {r_byte, r_bitcnt};
  assign w_bit = r_frame[5'd23 - w_pos];

  // Line drive decoded from registered state so a released SCL is visible
  // on scl_in in the very first clock of the high phase (no false stall).
  always_comb begin
    w_scl_oe = 1'b0;
    w_sda_oe = 1'b0;
    case (r_state)
      S_START: begin
        w_sda_oe = (r_qph != 2'd0);
        w_scl_oe = (r_qph == 2'd2);
      end
      S_BIT: begin
        w_scl_oe = (r_qph < 2'd2);
        w_sda_oe = ~w_bit;
      end
      S_ACK: begin
        w_scl_oe = (r_qph < 2'd2);
      end
      S_STOP: begin
        w_scl_oe = (r_qph == 2'd0);
        w_sda_oe = (r_qph != 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_qcnt      <= '0;
      r_qph       <= '0;
      r_bitcnt    <= '0;
      r_byte      <= '0;
      r_gap       <= '0;
      r_retry     <= '0;
      r_idx       <= '0;
      r_frame     <= '0;
      r_last      <= 1'b0;
      r_nack      <= 1'b0;
      r_fetch2    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_index <= '0;
    end else begin
      r_done <= 1'b0;

      if (!w_active)     r_qcnt <= '0;
      else if (!w_stall) r_qcnt <= w_q ? '0 : r_qcnt + QW'(1);

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_error  <= 1'b0;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_fetch2 <= 1'b0;
            r_state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Second clock: table data for the new address is now valid.
          if (!r_fetch2) begin
            r_fetch2 <= 1'b1;
          end else begin
            r_fetch2 <= 1'b0;
            r_frame  <= {bus.tbl_data[23:17], 1'b0, bus.tbl_data[15:0]};
            r_last   <= bus.tbl_data[16];
            r_retry  <= '0;
            r_qph    <= '0;
            r_bitcnt <= '0;
            r_byte   <= '0;
            r_nack   <= 1'b0;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (w_q) begin
            if (r_qph == 2'd2) begin
              r_qph   <= '0;
              r_state <= S_BIT;
            end else begin
              r_qph <= r_qph + 2'd1;
            end
          end
        end
        S_BIT: begin
          if (w_q) begin
            r_qph <= r_qph + 2'd1;
            if (r_qph == 2'd3) begin
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) r_state <= S_ACK;
            end
          end
        end
        S_ACK: begin
          if (w_q) begin
            r_qph <= r_qph + 2'd1;
            if (r_qph == 2'd3) begin
              if (bus.sda_in) begin
                r_nack  <= 1'b1;
                r_state <= S_STOP;
              end else if (r_byte == 2'd2) begin
                r_state <= S_STOP;
              end else begin
                r_byte  <= r_byte + 2'd1;
                r_state <= S_BIT;
              end
            end
          end
        end
        S_STOP: begin
          if (w_q) begin
            if (r_qph == 2'd2) begin
              r_qph   <= '0;
              r_gap   <= '0;
              r_state <= S_GAP;
            end else begin
              r_qph <= r_qph + 2'd1;
            end
          end
        end
        S_GAP: begin
          if (w_q) begin
            if (r_gap == GW'(GAP_QTRS - 1)) begin
              if (r_nack && (r_retry < RW'(MAX_RETRY))) begin
                r_retry  <= r_retry + RW'(1);
                r_qph    <= '0;
                r_bitcnt <= '0;
                r_byte   <= '0;
                r_nack   <= 1'b0;
                r_state  <= S_START;
              end else if (r_nack) begin
                r_error     <= 1'b1;
                r_err_index <= r_idx;
                r_busy      <= 1'b0;
                r_state     <= S_IDLE;
              end else if (r_last || (r_idx == IDX_W'(NUM_ENTRIES - 1))) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_idx   <= r_idx + IDX_W'(1);
                r_state <= S_FETCH;
              end
            end else begin
              r_gap <= r_gap + GW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.error     = r_error;
  assign bus.err_index = r_err_index;
  assign bus.tbl_addr  = r_idx;
  assign bus.scl_oe    = w_scl_oe;
  assign bus.sda_oe    = w_sda_oe;

endmodule
